// File: rtl/exec_unit.sv
// Execute stage feeding the register file: ALU ops plus a shift-add multiplier.
// Latency: WB two cycles after start for logic/arith ops, seventeen cycles for MUL.
// Backpressure: none downstream; start is ignored while busy and is not queued.
module exec_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [SEL_WIDTH-1:0]  dest_reg,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  write_enable,
  output logic [SEL_WIDTH-1:0]  select_reg,
  output logic                  zero_flag,
  output logic                  carry_flag
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  state_t                    state;
  logic [2:0]                op_q;
  logic [SEL_WIDTH-1:0]      sel_q;
  logic [DATA_WIDTH-1:0]     a_q;
  logic [DATA_WIDTH-1:0]     b_q;
  logic [2*DATA_WIDTH-1:0]   acc_q;
  logic [2*DATA_WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [DATA_WIDTH:0]       sum_w;
  logic [DATA_WIDTH:0]       diff_w;
  logic [2*DATA_WIDTH-1:0]   shl_w;
  logic [DATA_WIDTH-1:0]     exec_res;
  logic                      exec_carry;
  logic [2*DATA_WIDTH-1:0]   mul_sum;

  // Single-cycle ALU result and carry candidate from the latched operands.
  always_comb begin
    sum_w      = {1'b0, a_q} + {1'b0, b_q};
    diff_w     = {1'b0, a_q} - {1'b0, b_q};
    shl_w      = {{DATA_WIDTH{1'b0}}, a_q} << b_q[3:0];
    exec_res   = '0;
    exec_carry = 1'b0;
    case (op_q)
      OP_ADD: begin exec_res = sum_w[DATA_WIDTH-1:0];  exec_carry = sum_w[DATA_WIDTH];  end
      OP_SUB: begin exec_res = diff_w[DATA_WIDTH-1:0]; exec_carry = diff_w[DATA_WIDTH]; end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_NOT: exec_res = ~a_q;
      OP_SHL: begin
        exec_res   = shl_w[DATA_WIDTH-1:0];
        exec_carry = |shl_w[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: begin exec_res = '0; exec_carry = 1'b0; end
    endcase
  end

  // One shift-add step: the multiplier is shifted right so bit 0 is always the current bit.
  always_comb begin
    mul_sum = acc_q + (b_q[0] ? mcand_q : '0);
  end

  // Control FSM with registered outputs; strobes default low and are raised only on entry to WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      op_q         <= '0;
      sel_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      write_enable <= 1'b0;
      alu_result   <= '0;
      select_reg   <= '0;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
    end else begin
      done         <= 1'b0;
      write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= opcode;
            sel_q   <= dest_reg;
            a_q     <= operand_a;
            b_q     <= operand_b;
            acc_q   <= '0;
            mcand_q <= {{DATA_WIDTH{1'b0}}, operand_a};
            cnt_q   <= '0;
            busy    <= 1'b1;
            state   <= (opcode == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          alu_result   <= exec_res;
          carry_flag   <= exec_carry;
          zero_flag    <= (exec_res == '0);
          select_reg   <= sel_q;
          done         <= 1'b1;
          write_enable <= 1'b1;
          state        <= S_WB;
        end
        S_MUL: begin
          acc_q   <= mul_sum;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            alu_result   <= mul_sum[DATA_WIDTH-1:0];
            carry_flag   <= |mul_sum[2*DATA_WIDTH-1:DATA_WIDTH];
            zero_flag    <= (mul_sum[DATA_WIDTH-1:0] == '0);
            select_reg   <= sel_q;
            done         <= 1'b1;
            write_enable <= 1'b1;
            state        <= S_WB;
          end
        end
        S_WB: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
